// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
package hilo_pkg;

    // Operation encodings as issued by EX
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } hilo_state_t;

    // LO after a divide by zero is all ones; replicated to WIDTH at the use site
    localparam logic DIV0_LO_FILL = 1'b1;

endpackage

// File: rtl/hilo_iter_core.sv
// Unsigned iterative datapath: LSB-first shift-add multiply and restoring
// divide, one bit per step, sharing a single 2*WIDTH accumulator.
module hilo_iter_core
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_is_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_top;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;

    // Next accumulator value for one multiply step and one divide step
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        // Divide: shift left by one, trial-subtract the divisor from the
        // partial remainder (WIDTH+1 bits so the shifted-out MSB is kept).
        // The trial sign bit is clear exactly when the subtraction fits.
        w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
        w_trial    = w_div_top - {1'b0, r_b};
        if (!w_trial[WIDTH])
            w_div_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        else
            w_div_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end

    // Accumulator load on start, iterate on step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
        end else if (i_start) begin
            // Multiplier (or dividend) sits in the low half; divisor/multiplicand held apart
            r_acc    <= {{WIDTH{1'b0}}, i_is_div ? i_a : i_b};
            r_b      <= i_is_div ? i_b : i_a;
            r_is_div <= i_is_div;
        end else if (i_step) begin
            r_acc    <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    // Multiply: {hi,lo} = product. Divide: hi = remainder, lo = quotient.
    assign o_hi = r_acc[2*WIDTH-1:WIDTH];
    assign o_lo = r_acc[WIDTH-1:0];

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO unit: control FSM, operand sign handling, MTHI/MTLO override
// tracking and the architectural HI/LO registers.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             op_ready,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done
);

    hilo_state_t r_state, w_state_nxt;

    logic [CNT_W-1:0] r_cnt;
    logic             r_is_div;
    logic             r_neg_q;    // product / quotient must be negated
    logic             r_neg_r;    // remainder must be negated (dividend was negative)
    logic             r_div0;
    logic             r_ovr_hi;
    logic             r_ovr_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_signed;
    logic             w_is_div;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic             w_accept;
    logic             w_step;
    logic             w_commit;
    logic             w_in_flight;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    // Operand decode and magnitude extraction for the unsigned core
    always_comb begin
        w_is_div = op_code[1];
        w_signed = ~op_code[0];
        w_abs_a  = (w_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        w_abs_b  = (w_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    assign w_in_flight = (r_state == CALC) || (r_state == FINISH);
    assign w_accept    = (r_state == IDLE) && op_valid && !cancel;
    assign w_step      = (r_state == CALC) && !cancel;
    assign w_commit    = (r_state == FINISH) && !cancel;

    hilo_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept),
        .i_step   (w_step),
        .i_is_div (w_is_div),
        .i_a      (w_abs_a),
        .i_b      (w_abs_b),
        .o_hi     (w_core_hi),
        .o_lo     (w_core_lo)
    );

    // Sign correction of the unsigned core result; most-negative / -1
    // wraps to {HI=0, LO=most-negative} without a special case.
    always_comb begin
        w_prod   = {w_core_hi, w_core_lo};
        w_res_hi = w_core_hi;
        w_res_lo = w_core_lo;
        if (r_is_div) begin
            w_res_hi = r_neg_r ? -w_core_hi : w_core_hi;
            if (r_div0)
                w_res_lo = {WIDTH{DIV0_LO_FILL}};
            else
                w_res_lo = r_neg_q ? -w_core_lo : w_core_lo;
        end else if (r_neg_q) begin
            {w_res_hi, w_res_lo} = -w_prod;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic; cancel aborts from any in-flight state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = CALC;
            CALC: begin
                if (cancel)                              w_state_nxt = IDLE;
                else if (r_cnt == CNT_W'(WIDTH - 1))     w_state_nxt = FINISH;
            end
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-operation context: counter, result sign flags, op type
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_is_div;
            r_neg_q  <= w_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            r_neg_r  <= w_signed && op_a[WIDTH-1];
            r_div0   <= w_is_div && (op_b == '0);
        end else if (w_step) begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Override flags: a direct write while in flight makes FINISH skip that half
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovr_hi <= 1'b0;
            r_ovr_lo <= 1'b0;
        end else if (w_accept) begin
            r_ovr_hi <= 1'b0;
            r_ovr_lo <= 1'b0;
        end else if (w_in_flight) begin
            if (hi_we) r_ovr_hi <= 1'b1;
            if (lo_we) r_ovr_lo <= 1'b1;
        end
    end

    // HI/LO registers: direct write beats the computed value in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (hi_we)                     r_hi <= hi_wdata;
            else if (w_commit && !r_ovr_hi) r_hi <= w_res_hi;
            if (lo_we)                     r_lo <= lo_wdata;
            else if (w_commit && !r_ovr_lo) r_lo <= w_res_lo;
        end
    end

    // Completion pulse in the cycle after HI/LO take the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_done <= 1'b0;
        else      r_done <= w_commit;
    end

    assign op_ready = (r_state == IDLE);
    assign busy     = w_in_flight;
    assign done     = r_done;
    assign hi_out   = r_hi;
    assign lo_out   = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv with hand-computed expected values.
module tb_hilo_muldiv;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         op_valid = 1'b0;
    logic [1:0]   op_code = 2'b00;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         op_ready;
    logic         cancel = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] hi_wdata = '0;
    logic [W-1:0] lo_wdata = '0;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;
    logic         busy;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc;
    int dp;

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .cancel(cancel),
        .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an op for exactly one edge; returns #1 after the accepting edge
    task automatic start_op(input logic [1:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        step();
        op_valid = 1'b0;
    endtask

    // Count edges until busy drops (bounded); also count done pulses seen while busy
    task automatic wait_idle(output int c, output int d);
        c = 0; d = 0;
        while (busy && c < 200) begin
            if (done) d++;
            step();
            c++;
        end
    endtask

    // Full op: accept, check busy window, done pulse and results; leaves the bench in the done cycle
    task automatic run(input string tag, input logic [1:0] code, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int c, d;
        start_op(code, a, b);
        chk({tag, " accepted"}, {63'd0, busy}, 64'd1);
        wait_idle(c, d);
        chk({tag, " busy cycles"}, 64'(c), 64'd33);
        chk({tag, " done"}, {62'd0, d[0], done}, 64'd1);
        chk({tag, " hi:lo"}, {hi_out, lo_out}, {eh, el});
    endtask

    initial begin
        // Reset state
        step(); step();
        chk("rst hi:lo", {hi_out, lo_out}, 64'd0);
        chk("rst busy/done/ready", {61'd0, busy, done, op_ready}, 64'b001);
        rst = 1'b1;
        step();

        // 1: MULT -3 * 7 = -21
        run("mult -3*7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB);
        step();
        chk("mult done cleared", {63'd0, done}, 64'd0);

        // 2: MULTU max*max
        run("multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        // 3: divides, each accepted back-to-back in the previous done cycle
        run("divu 100/7", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE);
        run("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
        run("div ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        run("mult minneg^2", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("div -9/0", 2'b10, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF);
        step();

        // 4: DIV 5/0 with op_valid presented while busy
        start_op(2'b10, 32'd5, 32'd0);
        step(); step(); step();
        op_valid = 1'b1; op_code = 2'b01; op_a = 32'd2; op_b = 32'd3;
        #1;
        chk("busy op_ready", {63'd0, op_ready}, 64'd0);
        step();
        op_valid = 1'b0;
        chk("busy still", {63'd0, busy}, 64'd1);
        wait_idle(cyc, dp);
        chk("div0 remaining cycles", 64'(cyc), 64'd29);
        chk("div0 hi:lo", {hi_out, lo_out}, {32'h5, 32'hFFFFFFFF});
        step();
        chk("ignored op not run", {63'd0, busy}, 64'd0);

        // 5: cancel on the 10th CALC cycle
        hi_we = 1'b1; hi_wdata = 32'h11; lo_we = 1'b1; lo_wdata = 32'h22;
        step();
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mt hi:lo", {hi_out, lo_out}, {32'h11, 32'h22});
        start_op(2'b00, 32'd3, 32'd7);
        repeat (9) step();
        chk("pre-cancel busy", {63'd0, busy}, 64'd1);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        chk("cancel idle", {62'd0, busy, op_ready}, 64'b01);
        dp = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dp++;
            step();
        end
        chk("cancel no done", 64'(dp), 64'd0);
        chk("cancel hi:lo", {hi_out, lo_out}, {32'h11, 32'h22});

        // 6a: MTHI mid-CALC overrides computed HI
        start_op(2'b11, 32'd100, 32'd7);
        repeat (5) step();
        hi_we = 1'b1; hi_wdata = 32'hABCD;
        step();
        hi_we = 1'b0;
        chk("mthi immediate", {32'd0, hi_out}, {32'd0, 32'hABCD});
        wait_idle(cyc, dp);
        chk("ovr done", {63'd0, done}, 64'd1);
        chk("ovr hi:lo", {hi_out, lo_out}, {32'hABCD, 32'hE});
        step();

        // 6b: MTLO in the FINISH cycle beats the computed quotient
        start_op(2'b11, 32'd100, 32'd7);
        repeat (32) step();
        lo_we = 1'b1; lo_wdata = 32'h55;
        step();
        lo_we = 1'b0;
        chk("finish mtlo hi:lo", {hi_out, lo_out}, {32'h2, 32'h55});
        chk("finish mtlo done", {63'd0, done}, 64'd1);
        step();

        // 6c: reset mid-CALC
        start_op(2'b00, 32'd9, 32'd9);
        repeat (5) step();
        rst = 1'b0;
        #1;
        chk("mid rst hi:lo", {hi_out, lo_out}, 64'd0);
        chk("mid rst busy/done", {62'd0, busy, done}, 64'd0);
        step();
        rst = 1'b1;
        step();
        chk("post rst ready", {63'd0, op_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
Parametrised HI/LO unit for the 5-stage MIPS pipeline. It holds the HI and LO registers and computes their values for MULT, MULTU, DIV and DIVU using an iterative one-bit-per-cycle datapath. It also accepts direct MTHI/MTLO writes. It sits beside the EX stage: EX issues operations, MEM/WB read hi_out/lo_out, and the hazard unit stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO register width; must be at least 4.
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  EX presents an operation
op_code  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
op_a  in  WIDTH  rs operand (multiplicand or dividend)
op_b  in  WIDTH  rt operand (multiplier or divisor)
op_ready  out  1  unit can accept an operation (state IDLE)
cancel  in  1  exception flush; abort the in-flight operation
hi_we  in  1  MTHI write enable
lo_we  in  1  MTLO write enable
hi_wdata  in  WIDTH  MTHI data
lo_wdata  in  WIDTH  MTLO data
hi_out  out  WIDTH  registered HI value
lo_out  out  WIDTH  registered LO value
busy  out  1  operation in flight
done  out  1  one-cycle pulse in the cycle after HI/LO take the result

Behaviour:
- Reset (rst=0, asynchronous): HI=0, LO=0, state=IDLE, busy=0, done=0, counter=0, both override flags cleared. Reset during CALC aborts the operation and commits no result.
- States:
  - IDLE: op_ready=1, busy=0. Go to CALC when op_valid=1 and cancel=0. On the accepting edge latch |a|, |b| (signed ops take the absolute value; unsigned ops pass through), the result sign flags and the op type; clear counter and override flags.
  - CALC: op_ready=0, busy=1. One iteration per edge: shift-add for multiply, restoring subtract for divide. When the counter reaches WIDTH, go to FINISH.
  - FINISH: busy=1. Apply sign correction, write HI/LO, return to IDLE, assert done for the following cycle.
- Latency: accepted at edge N, HI/LO updated at edge N+WIDTH+1, done high during cycle N+WIDTH+2. Back-to-back operations accept at the earliest at edge N+WIDTH+2.
- Multiply results: {HI,LO} = full 2*WIDTH-bit product. For signed ops, negate the product when the operand signs differ.
- Divide results: LO = quotient, HI = remainder.
  - Quotient is negative when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = op_a unchanged, for both signed and unsigned.
  - Signed overflow (most-negative / -1): LO = most-negative, HI = 0. This wraps naturally; no special case is needed.
- Direct writes:
  - hi_we/lo_we write HI/LO at the next edge in any state.
  - A direct write during CALC or FINISH sets that half's override flag. FINISH then skips that half, so the later MTHI/MTLO wins in program order.
  - A direct write in the same cycle as FINISH beats the computed value.
- cancel:
  - In CALC or FINISH: return to IDLE at the next edge. HI/LO keep their prior values, except for any direct write in that same cycle; done is not asserted.
  - In IDLE: ignored, and it blocks acceptance of a simultaneous op_valid.
- op_valid while busy: ignored. The hazard unit must hold EX; the unit never queues operations.
- hi_out/lo_out are direct register outputs with no bypass of in-flight results.

Decomposition:
- Shared package hilo_pkg: op_code encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE, CALC, FINISH), and the divide-by-zero LO constant.
- Sub-module hilo_iter_core: the WIDTH-cycle shift-add / restoring-divide datapath with start/step inputs, a 2*WIDTH accumulator, and unsigned results only.
- Top module: FSM, sign handling, override flags and the HI/LO registers.

Test Plan:
1. Reset, then MULT a=0xFFFFFFFD (-3), b=7 -> after 33 edges HI=0xFFFFFFFF, LO=0xFFFFFFEB; done pulses once; busy high for exactly 33 cycles.
2. MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
3. DIVU 100/7 -> LO=0xE, HI=0x2. DIV 0xFFFFFFF9/2 (-7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIV 5/0 -> LO=0xFFFFFFFF, HI=0x5. Also: op_valid asserted while busy is not accepted, and op_ready stays 0.
5. Start MULT with HI=0x11, LO=0x22, assert cancel on the 10th CALC cycle -> IDLE next edge; HI=0x11, LO=0x22; no done pulse.
6. Start DIVU 100/7, pulse hi_we with 0xABCD mid-CALC -> final HI=0xABCD, LO=0xE. Separately, assert rst mid-CALC -> HI=LO=0, busy=0 immediately.
